// File: rtl/conv_loop_nest_if.sv
// Handshake and index bus between the layer controller and conv_loop_nest.
//   master : layer controller (drives start/abort/stall and the layer shape)
//   slave  : conv_loop_nest   (drives busy/valid, the index tuple and status pulses)
// KW and CW must match the parameters of the conv_loop_nest instance.
interface conv_loop_nest_if #(
  parameter int KW = 4,
  parameter int CW = 8
);
  // controller -> generator
  logic          start;
  logic          abort;
  logic          stall;
  logic [KW-1:0] cfg_k;
  logic [CW-1:0] cfg_in_ch;
  logic [CW-1:0] cfg_out_size;
  logic [CW-1:0] cfg_out_ch;

  // generator -> controller / address generators
  logic          busy;
  logic          valid;
  logic [CW-1:0] m;
  logic [CW-1:0] r;
  logic [CW-1:0] c;
  logic [CW-1:0] n;
  logic [KW-1:0] i;
  logic [KW-1:0] j;
  logic          pix_done;
  logic          layer_done;
  logic          cfg_err;

  modport master (
    output start, abort, stall, cfg_k, cfg_in_ch, cfg_out_size, cfg_out_ch,
    input  busy, valid, m, r, c, n, i, j, pix_done, layer_done, cfg_err
  );

  modport slave (
    input  start, abort, stall, cfg_k, cfg_in_ch, cfg_out_size, cfg_out_ch,
    output busy, valid, m, r, c, n, i, j, pix_done, layer_done, cfg_err
  );
endinterface

// File: rtl/conv_loop_nest.sv
// Six-level loop-index generator for a convolution layer.
// Sweeps m (out ch) > r (row) > c (col) > n (input-ch group) > i (kernel row)
// > j (kernel col), j fastest, producing one tuple per non-stalled cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - conv_loop_nest_if.slave: start/abort/stall, layer shape in,
//          busy/valid, m/r/c/n/i/j, pix_done, layer_done, cfg_err out
module conv_loop_nest #(
  parameter int KW    = 4,
  parameter int CW    = 8,
  parameter int LANES = 4
) (
  input logic              clk,
  input logic              rst,
  conv_loop_nest_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;

  // Layer shape latched on an accepted start
  logic [KW-1:0] k_q;
  logic [CW-1:0] s_q;
  logic [CW-1:0] m_max_q;
  logic [CW-1:0] ng_q;

  // Index registers; they are zero whenever the state is IDLE
  logic [CW-1:0] m_q, r_q, c_q, n_q;
  logic [KW-1:0] i_q, j_q;

  logic          layer_done_q;
  logic          cfg_err_q;

  // Group count is formed at CW+1 bits so in_ch + LANES-1 cannot wrap;
  // the quotient always fits back into CW bits.
  logic [CW:0]   ng_sum;
  logic [CW-1:0] ng_d;
  logic          cfg_bad;

  assign ng_sum  = {1'b0, bus.cfg_in_ch} + (CW+1)'(LANES - 1);
  assign ng_d    = CW'(ng_sum / (CW+1)'(LANES));
  assign cfg_bad = (bus.cfg_k == '0) || (bus.cfg_in_ch == '0) ||
                   (bus.cfg_out_size == '0) || (bus.cfg_out_ch == '0);

  // "At max" flags for each level and the combinational carry chain
  logic j_last, i_last, n_last, c_last, r_last, m_last;
  logic carry_i, carry_n, carry_c, carry_r, carry_m, last_tuple;

  assign j_last = (j_q == k_q - KW'(1));
  assign i_last = (i_q == k_q - KW'(1));
  assign n_last = (n_q == ng_q - CW'(1));
  assign c_last = (c_q == s_q - CW'(1));
  assign r_last = (r_q == s_q - CW'(1));
  assign m_last = (m_q == m_max_q - CW'(1));

  assign carry_i    = j_last;
  assign carry_n    = carry_i & i_last;
  assign carry_c    = carry_n & n_last;
  assign carry_r    = carry_c & c_last;
  assign carry_m    = carry_r & r_last;
  assign last_tuple = carry_m & m_last;

  // Next index values for one advance. On the final tuple every level
  // wraps, so the indices land on zero without a separate clear.
  logic [CW-1:0] m_nx, r_nx, c_nx, n_nx;
  logic [KW-1:0] i_nx, j_nx;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    m_nx = m_q;
    r_nx = r_q;
    c_nx = c_q;
    n_nx = n_q;
    i_nx = i_q;
    j_nx = j_last ? '0 : j_q + KW'(1);
    if (carry_i) i_nx = i_last ? '0 : i_q + KW'(1);
    if (carry_n) n_nx = n_last ? '0 : n_q + CW'(1);
    if (carry_c) c_nx = c_last ? '0 : c_q + CW'(1);
    if (carry_r) r_nx = r_last ? '0 : r_q + CW'(1);
    if (carry_m) m_nx = m_last ? '0 : m_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the latched shape registers are reset too, so a reset leaves no
  // stale layer shape behind (they are plain flops, not a RAM).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k_q          <= '0;
      s_q          <= '0;
      m_max_q      <= '0;
      ng_q         <= '0;
      m_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      n_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      layer_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      if (state == IDLE) begin
        // start beats a simultaneous abort here: abort is only acted on in RUN
        if (bus.start) begin
          if (cfg_bad) begin
            cfg_err_q <= 1'b1;
          end else begin
            k_q     <= bus.cfg_k;
            s_q     <= bus.cfg_out_size;
            m_max_q <= bus.cfg_out_ch;
            ng_q    <= ng_d;
            state   <= RUN;
          end
        end
      end else begin
        if (bus.abort) begin
          state <= IDLE;
          m_q   <= '0;
          r_q   <= '0;
          c_q   <= '0;
          n_q   <= '0;
          i_q   <= '0;
          j_q   <= '0;
        end else if (!bus.stall) begin
          m_q <= m_nx;
          r_q <= r_nx;
          c_q <= c_nx;
          n_q <= n_nx;
          i_q <= i_nx;
          j_q <= j_nx;
          if (last_tuple) begin
            state        <= IDLE;
            layer_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.valid      = (state == RUN);
  assign bus.m          = m_q;
  assign bus.r          = r_q;
  assign bus.c          = c_q;
  assign bus.n          = n_q;
  assign bus.i          = i_q;
  assign bus.j          = j_q;
  // Decoded from registered indices, so it lines up with its own tuple
  assign bus.pix_done   = (state == RUN) & j_last & i_last & n_last;
  assign bus.layer_done = layer_done_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule
